hdmi_timing_gen: RTL
====================

Name: hdmi_timing_gen

Overview:
- Generates HDMI/CEA video timing (hs, vs, de, pixel coordinates) for the scaler/HDMI encoder.
- Runs downstream of the video-parameter analyser and consumes its pal and vreset outputs.
- pal selects 720x576@50 or 720x480@60 timing.
- A vreset pulse snaps the counters to a fixed position, so HDMI active video stays aligned with the Atari ST frame.

Parameters:
- SYNC_HPOS, 0, horizontal counter value loaded on vreset; must be < 858.
- SYNC_VPOS, 0, vertical counter value loaded on vreset; must be < 525.

Ports:
- clk  in  1  pixel clock; same domain as the analyser outputs.
- reset_n  in  1  asynchronous, active-low reset.
- pal  in  1  video standard request: 1 = 576p50, 0 = 480p60.
- vreset  in  1  single-cycle resync pulse.
- hs  out  1  horizontal sync, active low.
- vs  out  1  vertical sync, active low.
- de  out  1  data enable; high inside the active area.
- x  out  10  active pixel column, 0..719; holds 0 outside the active area.
- y  out  10  active line, 0..575 or 0..479; holds 0 outside the active area.
- frame_start  out  1  one-cycle pulse when hcnt=0 and vcnt=0.
- locked  out  1  high once a vreset has aligned the current mode.
- mode  out  1  standard actually in use (1 = PAL).

Behaviour:
- Reset values:
  - Outputs: hs=1, vs=1, de=0, x=0, y=0, frame_start=0, locked=0, mode=1.
  - Internal: hcnt=0, vcnt=0.
- Counter origin: hcnt/vcnt = 0 at the first active pixel of the first active line. Horizontal order is active, front porch, sync, back porch; vertical order is the same.
- PAL timing:
  - Horizontal: total 864, active 720, front porch 12, sync 64, back porch 68.
  - Vertical: total 625, active 576, front porch 5, sync 5, back porch 39.
- NTSC timing:
  - Horizontal: total 858, active 720, front porch 16, sync 62, back porch 60.
  - Vertical: total 525, active 480, front porch 9, sync 6, back porch 30.
- Each cycle, hcnt increments and wraps at htotal-1 to 0. On that wrap, vcnt increments and wraps at vtotal-1 to 0.
- Output registration: all outputs are registered and decoded from the current counters, so outputs lag the counters by 1 cycle.
  - hs low for hcnt in [hact+hfp, hact+hfp+hsync-1].
  - vs low for vcnt in [vact+vfp, vact+vfp+vsync-1], changing at the same hcnt=0 boundary as the line start.
- Mode update: the mode register samples pal only at end of frame (hcnt=htotal-1 and vcnt=vtotal-1), or on vreset. pal toggling mid-frame has no effect until one of those points.
- vreset sampled high:
  - Next cycle: hcnt=SYNC_HPOS, vcnt=SYNC_VPOS, mode=pal, locked=1.
  - vreset overrides a simultaneous end-of-frame wrap.
  - vreset asserted on consecutive cycles reloads each cycle.
- locked clears:
  - on reset;
  - at an end-of-frame mode update where pal differs from mode.
- Mode switch at end of frame: counters wrap to 0 and take the new totals from the next cycle. No out-of-range counter values are possible, because the load targets are < the NTSC totals.
- Asynchronous reset mid-frame: all state returns to reset values immediately. Counting restarts from 0 in PAL mode after release.
- No backpressure: the block free-runs.

Decomposition:
- Package video_timing_pkg:
  - struct of timing constants: htotal, hact, hfp, hsync, vtotal, vact, vfp, vsync;
  - TIMING_PAL and TIMING_NTSC constants;
  - a 1-bit mode enum (MODE_NTSC=0, MODE_PAL=1).
- Sub-module video_counter: a generic hcnt/vcnt pair with load port and runtime totals. The top handles mode selection, sync/de decoding and locked.

Test Plan:
- Reset release with pal=1, no vreset:
  - 864 cycles per line, 625 lines per frame; de high 720 cycles per line on 576 lines.
  - hs low 64 cycles starting 1 cycle after hcnt=732; vs low 5 lines.
  - frame_start period 540000 cycles.
- pal=0 applied mid-frame:
  - mode stays 1 until end of frame, then 858x525 timing, hs low 62, vs low 6 lines.
  - locked stays 0 throughout, since no vreset has occurred.
- Alignment and loss of lock (SYNC_HPOS=100, SYNC_VPOS=10):
  - vreset at arbitrary position: next cycle counters = (100,10); locked=1.
  - Subsequent frame_start occurs exactly 864*615-100 cycles later.
  - pal then toggled: locked drops at the next end of frame.
- vreset coinciding with the end-of-frame wrap: counters go to (SYNC_HPOS,SYNC_VPOS), not (0,0).
- reset_n asserted while de=1 at x=400: de, x and y go to 0 asynchronously; mode=1 and locked=0 after release.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing tables and mode encoding for the HDMI/CEA timing generator.
// Counter origin is the first active pixel; porches and sync follow the active area.
package video_timing_pkg;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t htotal;
    cnt_t hact;
    cnt_t hfp;
    cnt_t hsync;
    cnt_t vtotal;
    cnt_t vact;
    cnt_t vfp;
    cnt_t vsync;
  } timing_t;

  typedef enum logic {
    MODE_NTSC = 1'b0,
    MODE_PAL  = 1'b1
  } mode_e;

  localparam timing_t TIMING_PAL = '{
    htotal: 10'd864, hact: 10'd720, hfp: 10'd12, hsync: 10'd64,
    vtotal: 10'd625, vact: 10'd576, vfp: 10'd5,  vsync: 10'd5
  };

  localparam timing_t TIMING_NTSC = '{
    htotal: 10'd858, hact: 10'd720, hfp: 10'd16, hsync: 10'd62,
    vtotal: 10'd525, vact: 10'd480, vfp: 10'd9,  vsync: 10'd6
  };

  function automatic timing_t timing_of(input mode_e m);
    return (m == MODE_PAL) ? TIMING_PAL : TIMING_NTSC;
  endfunction

  // True when c lies in [start, start+len-1].
  function automatic logic in_window(input cnt_t c, input cnt_t start, input cnt_t len);
    return (c >= start) && (c < cnt_t'(start + len));
  endfunction

endpackage

// File: rtl/video_counter.sv
// Horizontal/vertical position counter pair with runtime totals and a load port.
// A load takes priority over the normal increment/wrap.
module video_counter
  import video_timing_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  cnt_t htotal,
  input  cnt_t vtotal,
  input  logic load,
  input  cnt_t hload,
  input  cnt_t vload,
  output cnt_t hcnt,
  output cnt_t vcnt,
  output logic frame_end
);

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  logic line_end;

  // Next-position computation: load, wrap at the totals, or step.
  always_comb begin
    line_end  = (hcnt_q >= cnt_t'(htotal - cnt_t'(1)));
    frame_end = line_end && (vcnt_q >= cnt_t'(vtotal - cnt_t'(1)));
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    if (load) begin
      hcnt_d = hload;
      vcnt_d = vload;
    end else if (line_end) begin
      hcnt_d = 10'd0;
      if (frame_end) begin
        vcnt_d = 10'd0;
      end else begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end else begin
      hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vcnt_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= 10'd0;
      vcnt_q <= 10'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

endmodule

// File: rtl/hdmi_timing_gen.sv
// HDMI/CEA 576p50 / 480p60 timing generator with vreset alignment to the source frame.
// Mode only changes at end of frame or on vreset; all outputs are registered decodes.
module hdmi_timing_gen
  import video_timing_pkg::*;
#(
  parameter int SYNC_HPOS = 0,
  parameter int SYNC_VPOS = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pal,
  input  logic       vreset,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       locked,
  output logic       mode
);

  localparam cnt_t LOAD_H = cnt_t'(SYNC_HPOS);
  localparam cnt_t LOAD_V = cnt_t'(SYNC_VPOS);

  mode_e   mode_q, mode_d;
  mode_e   pal_mode;
  logic    locked_q, locked_d;
  timing_t tm;
  cnt_t    hcnt, vcnt;
  logic    frame_end;

  logic    hs_q, hs_d;
  logic    vs_q, vs_d;
  logic    de_q, de_d;
  cnt_t    x_q, x_d;
  cnt_t    y_q, y_d;
  logic    frame_start_q, frame_start_d;

  assign pal_mode = pal ? MODE_PAL : MODE_NTSC;
  assign tm       = timing_of(mode_q);

  video_counter u_counter (
    .clk       (clk),
    .rst_n     (reset_n),
    .htotal    (tm.htotal),
    .vtotal    (tm.vtotal),
    .load      (vreset),
    .hload     (LOAD_H),
    .vload     (LOAD_V),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .frame_end (frame_end)
  );

  // Mode and lock tracking; vreset wins over a coincident end of frame.
  always_comb begin
    mode_d   = mode_q;
    locked_d = locked_q;
    if (vreset) begin
      mode_d   = pal_mode;
      locked_d = 1'b1;
    end else if (frame_end) begin
      mode_d = pal_mode;
      if (pal_mode != mode_q) begin
        locked_d = 1'b0;
      end else begin
        locked_d = locked_q;
      end
    end else begin
      mode_d   = mode_q;
      locked_d = locked_q;
    end
  end

  // Sync, data-enable and coordinate decode from the current counters.
  always_comb begin
    de_d          = (hcnt < tm.hact) && (vcnt < tm.vact);
    hs_d          = ~in_window(hcnt, cnt_t'(tm.hact + tm.hfp), tm.hsync);
    vs_d          = ~in_window(vcnt, cnt_t'(tm.vact + tm.vfp), tm.vsync);
    frame_start_d = (hcnt == 10'd0) && (vcnt == 10'd0);
    if (de_d) begin
      x_d = hcnt;
      y_d = vcnt;
    end else begin
      x_d = 10'd0;
      y_d = 10'd0;
    end
  end

  // Output and mode/lock registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= MODE_PAL;
      locked_q      <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      locked_q      <= locked_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign mode        = mode_q;

endmodule
